sfm_acc_feeder: RTL and testbench
=================================

# sfm_acc_feeder

Upstream driver for the softmax accumulator's add/mul interface. Accepts vector beats of exponentials (N_LANES lanes with per-lane strobe), plus an optional rescale factor per beat, and serializes them one element per handshake onto the accumulator's `add_*`/`mul_*` ports, honouring its `ready`. Sits between the exponential stage and the accumulator. Signals end of a row with a `done_o` pulse.

## Interface
- ADD_FPFORMAT, fpnew_pkg::FP32, format of addends; ADD_WIDTH = fp_width(ADD_FPFORMAT)
- MUL_FPFORMAT, fpnew_pkg::FP16ALT, format of rescale factor; MUL_WIDTH = fp_width(MUL_FPFORMAT)
- N_LANES, 4, lanes per input beat (>=1); LANE_W = max(1, $clog2(N_LANES))
- CNT_WIDTH, 16, width of issued-addend counter
---
- Clock/reset: one clock `clk_i`; reset `rst_ni` is synchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous soft clear, same effect as reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o
- in_data_i  in  N_LANES*ADD_WIDTH  lane i at bits [i*ADD_WIDTH +: ADD_WIDTH]
- in_strb_i  in  N_LANES  lane i valid
- in_fact_en_i  in  1  beat carries a rescale factor
- in_fact_i  in  MUL_WIDTH  rescale factor
- in_last_i  in  1  final beat of row
- acc_ready_i  in  1  accumulator ready (shared by add and mul)
- add_valid_o  out  1  addend valid
- add_o  out  ADD_WIDTH  addend
- mul_valid_o  out  1  factor valid
- mul_o  out  MUL_WIDTH  factor
- done_o  out  1  one-cycle pulse, row fully issued
- add_cnt_o  out  CNT_WIDTH  addends issued since reset/clear

## Operation
- States: IDLE, MUL, ADD, DONE. All outputs registered or decoded from state only; reset/clear: state IDLE, all valid/done outputs 0, data outputs 0, add_cnt_o 0, buffers 0.
- in_ready_o = (state == IDLE). Single beat buffer, no skid.
- IDLE, beat accepted: capture data, strobe, factor, fact_en, last. Next state: MUL if fact_en; else ADD if strobe != 0; else DONE if last; else IDLE.
- MUL: mul_valid_o=1, mul_o=factor. On acc_ready_i: ADD if strobe != 0, else DONE if last, else IDLE.
- ADD: add_valid_o=1, add_o = lane at lowest set bit of remaining strobe. On acc_ready_i: clear that bit, add_cnt_o++ (wraps at 2^CNT_WIDTH); if no bits remain: DONE if last else IDLE; else stay ADD with next lane.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Factor always issued before any addend of the same beat; lanes issued in ascending index; strobe-0 lanes never issued.
- add_valid_o and mul_valid_o never both high. Valid stays high, data stable, until acc_ready_i sampled high.
- Element values passed bit-exact; no arithmetic on data.
- clear_i/rst_ni mid-beat: buffered beat discarded, no done_o, outputs drop next cycle.

## Timing
- Beat accepted cycle N -> first mul/add valid at N+1.
- Throughput: one element per cycle while acc_ready_i=1; beat with k strobes and factor occupies 1 + 1 + k cycles (accept + mul + adds) minimum, plus 1 DONE cycle if last.
- acc_ready_i low: state holds, no counter change.
- Empty beat (strobe 0, no factor) consumed in 1 cycle; if last, done_o at N+1.
- in_ready_o low from N+1 until the cycle IDLE is re-entered.

## Configuration
- SFM_ACC_FEEDER_CNT_EN: defined -> add_cnt_o counter implemented as above. Undefined -> counter logic removed, add_cnt_o tied to 0; all other behaviour identical.

## Test plan
- Beat N_LANES=4, strobe 4'b1111, data {0x40800000,0x40400000,0x40000000,0x3F800000}, no factor, last=1, acc_ready_i=1 -> add_o 0x3F800000,0x40000000,0x40400000,0x40800000 on 4 consecutive cycles, done_o pulse next cycle, add_cnt_o=4.
- Beat with fact_en=1, factor 0x3F00, strobe 4'b0101 -> mul_o=0x3F00 first, then lanes 0 and 2 only; no done_o when last=0; in_ready_o returns high.
- acc_ready_i low for 3 cycles during ADD lane 1 -> add_valid_o held, add_o stable, counter unchanged; resumes on ready.
- Empty beat strobe 0, fact_en=0, last=1 -> no add/mul valid, done_o one cycle after accept.
- clear_i asserted while in ADD with 2 lanes left -> next cycle state IDLE, valids 0, add_cnt_o 0, no done_o; rst_ni low same check.
- Counter wrap with CNT_WIDTH=4: issue 17 addends -> add_cnt_o=1; with macro undefined add_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/sfm_acc_feeder.sv
// sfm_acc_feeder: serializes exponential beats (factor first, then strobed lanes) onto the softmax accumulator add/mul ports.
// Widths default to FP32 addends and FP16ALT factors.
// Define SFM_ACC_FEEDER_CNT_EN to implement the issued-addend counter on add_cnt_o; otherwise it is tied to 0.
module sfm_acc_feeder #(
    parameter int ADD_WIDTH = 32,
    parameter int MUL_WIDTH = 16,
    parameter int N_LANES   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [N_LANES*ADD_WIDTH-1:0] in_data_i,
    input  logic [N_LANES-1:0]           in_strb_i,
    input  logic                         in_fact_en_i,
    input  logic [MUL_WIDTH-1:0]         in_fact_i,
    input  logic                         in_last_i,
    input  logic                         acc_ready_i,
    output logic                         add_valid_o,
    output logic [ADD_WIDTH-1:0]         add_o,
    output logic                         mul_valid_o,
    output logic [MUL_WIDTH-1:0]         mul_o,
    output logic                         done_o,
    output logic [CNT_WIDTH-1:0]         add_cnt_o
);
    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
    state_t                       r_state, w_next;
    logic [N_LANES*ADD_WIDTH-1:0] r_data;
    logic [N_LANES-1:0]           r_strb, w_bit, w_rem;
    logic [MUL_WIDTH-1:0]         r_fact;
    logic                         r_last;
    logic [ADD_WIDTH-1:0]         w_lane;
    // select the lowest still-pending lane and its data
    always_comb begin
        w_bit  = '0;
        w_lane = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (r_strb[i]) begin
                w_bit    = '0;
                w_bit[i] = 1'b1;
                w_lane   = r_data[i*ADD_WIDTH +: ADD_WIDTH];
            end
        end
    end
    assign w_rem = r_strb & ~w_bit;
    // next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid_i) w_next = in_fact_en_i ? MUL : |in_strb_i ? ADD : in_last_i ? DONE : IDLE;
            MUL:  if (acc_ready_i) w_next = |r_strb ? ADD : r_last ? DONE : IDLE;
            ADD:  if (acc_ready_i) w_next = |w_rem ? ADD : r_last ? DONE : IDLE;
            DONE: w_next = IDLE;
        endcase
    end
    // state register and single beat buffer; strobe bits retire as lanes are accepted
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_strb  <= '0;
            r_fact  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid_i) begin
                r_data <= in_data_i;
                r_strb <= in_strb_i;
                r_fact <= in_fact_i;
                r_last <= in_last_i;
            end else if (r_state == ADD && acc_ready_i) begin
                r_strb <= w_rem;
            end
        end
    end
    assign in_ready_o  = r_state == IDLE;
    assign add_valid_o = r_state == ADD;
    assign mul_valid_o = r_state == MUL;
    assign done_o      = r_state == DONE;
    assign add_o       = add_valid_o ? w_lane : '0;
    assign mul_o       = mul_valid_o ? r_fact : '0;
`ifdef SFM_ACC_FEEDER_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt;
    // count addends handed to the accumulator, wrapping naturally
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) r_cnt <= '0;
        else if (r_state == ADD && acc_ready_i) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
    assign add_cnt_o = r_cnt;
`else
    assign add_cnt_o = '0;
`endif
endmodule

// File: tb/tb_sfm_acc_feeder.sv
// tb_sfm_acc_feeder: scoreboard bench for sfm_acc_feeder (N_LANES=4, CNT_WIDTH=4).
module tb_sfm_acc_feeder;
    localparam int AW = 32;
    localparam int MW = 16;
    localparam int NL = 4;
    localparam int CW = 4;
`ifdef SFM_ACC_FEEDER_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clear_i = 1'b0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [NL*AW-1:0] in_data_i = '0;
    logic [NL-1:0]  in_strb_i = '0;
    logic           in_fact_en_i = 1'b0;
    logic [MW-1:0]  in_fact_i = '0;
    logic           in_last_i = 1'b0;
    logic           acc_ready_i = 1'b1;
    logic           add_valid_o;
    logic [AW-1:0]  add_o;
    logic           mul_valid_o;
    logic [MW-1:0]  mul_o;
    logic           done_o;
    logic [CW-1:0]  add_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [33:0] q[$];
    int unsigned model_cnt = 0;
    logic hold_add = 1'b0, hold_mul = 1'b0;
    logic [AW-1:0] prev_add = '0;
    logic [MW-1:0] prev_mul = '0;

    sfm_acc_feeder #(.ADD_WIDTH(AW), .MUL_WIDTH(MW), .N_LANES(NL), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_strb_i(in_strb_i), .in_fact_en_i(in_fact_en_i), .in_fact_i(in_fact_i),
        .in_last_i(in_last_i), .acc_ready_i(acc_ready_i),
        .add_valid_o(add_valid_o), .add_o(add_o), .mul_valid_o(mul_valid_o), .mul_o(mul_o),
        .done_o(done_o), .add_cnt_o(add_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // scoreboard monitor: sample between edges, pop expected element on each handshake
    always @(negedge clk_i) begin
        if (mon_en) begin
            logic [33:0] e;
            logic [CW-1:0] exp_cnt;
            exp_cnt = CNT_ON ? model_cnt[CW-1:0] : '0;
            n_cmp++;
            if (add_cnt_o !== exp_cnt) begin
                n_err++;
                $display("FAIL add_cnt: got %0d expected %0d", add_cnt_o, exp_cnt);
            end
            n_cmp++;
            if (add_valid_o && mul_valid_o) begin
                n_err++;
                $display("FAIL both_valid: add_valid_o and mul_valid_o both 1, expected at most one");
            end
            if (hold_add && add_valid_o) begin
                n_cmp++;
                if (add_o !== prev_add) begin
                    n_err++;
                    $display("FAIL add_stable: got %h expected %h", add_o, prev_add);
                end
            end
            if (hold_mul && mul_valid_o) begin
                n_cmp++;
                if (mul_o !== prev_mul) begin
                    n_err++;
                    $display("FAIL mul_stable: got %h expected %h", mul_o, prev_mul);
                end
            end
            hold_add = add_valid_o && !acc_ready_i;
            hold_mul = mul_valid_o && !acc_ready_i;
            prev_add = add_o;
            prev_mul = mul_o;
            if (mul_valid_o && acc_ready_i) begin
                e = (q.size() != 0) ? q.pop_front() : 34'h3_0000_0000;
                n_cmp++;
                if (e !== {2'd1, 16'h0, mul_o}) begin
                    n_err++;
                    $display("FAIL mul_item: got mul %h expected item %h", mul_o, e);
                end
            end
            if (add_valid_o && acc_ready_i) begin
                e = (q.size() != 0) ? q.pop_front() : 34'h3_0000_0000;
                n_cmp++;
                if (e !== {2'd0, add_o}) begin
                    n_err++;
                    $display("FAIL add_item: got add %h expected item %h", add_o, e);
                end
                model_cnt++;
            end
            if (done_o) begin
                e = (q.size() != 0) ? q.pop_front() : 34'h3_0000_0000;
                n_cmp++;
                if (e !== {2'd2, 32'h0}) begin
                    n_err++;
                    $display("FAIL done_item: got done expected item %h", e);
                end
            end
            if (!rst_ni || clear_i) model_cnt = 0;
        end
    end

    task automatic send(input logic [NL*AW-1:0] d, input logic [NL-1:0] s, input logic fe,
                        input logic [MW-1:0] f, input logic l, input bit rnd);
        int w = 0;
        while (!in_ready_o && w < 100) begin
            @(posedge clk_i); #1;
            if (rnd) acc_ready_i = 1'($urandom_range(0, 1));
            w++;
        end
        if (!in_ready_o) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready_o got %b expected 1", in_ready_o);
        end
        if (fe) q.push_back({2'd1, 16'h0, f});
        for (int i = 0; i < NL; i++) if (s[i]) q.push_back({2'd0, d[i*AW +: AW]});
        if (l) q.push_back({2'd2, 32'h0});
        in_valid_i = 1'b1; in_data_i = d; in_strb_i = s; in_fact_en_i = fe; in_fact_i = f; in_last_i = l;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        if (rnd) acc_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int budget, input bit rnd, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk_i); #1;
            cyc++;
            if (rnd) acc_ready_i = 1'($urandom_range(0, 1));
        end while (!(in_ready_o && q.size() == 0) && cyc < budget);
        acc_ready_i = 1'b1;
        if (!(in_ready_o && q.size() == 0)) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: in_ready_o %b pending %0d expected 1 and 0", in_ready_o, q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({in_ready_o, add_valid_o, mul_valid_o, done_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 1000", {in_ready_o, add_valid_o, mul_valid_o, done_o});
        end
        n_cmp++;
        if ({add_o, mul_o, add_cnt_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got add %h mul %h cnt %h expected 0", add_o, mul_o, add_cnt_o);
        end
        rst_ni = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_full_beat();
        int cyc;
        send({32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 4'b1111, 1'b0, 16'h0, 1'b1, 1'b0);
        wait_idle(50, 1'b0, cyc);
        n_cmp++;
        if (cyc != 5) begin
            n_err++;
            $display("FAIL full_beat_cycles: got %0d expected 5", cyc);
        end
        n_cmp++;
        if (add_cnt_o !== (CNT_ON ? 4'd4 : 4'd0)) begin
            n_err++;
            $display("FAIL full_beat_cnt: got %0d expected %0d", add_cnt_o, CNT_ON ? 4 : 0);
        end
    endtask

    task automatic test_factor();
        int cyc;
        send({32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b0101, 1'b1, 16'h3F00, 1'b0, 1'b0);
        n_cmp++;
        if (mul_valid_o !== 1'b1 || mul_o !== 16'h3F00) begin
            n_err++;
            $display("FAIL factor_first: got valid %b mul %h expected 1 3f00", mul_valid_o, mul_o);
        end
        wait_idle(50, 1'b0, cyc);
        n_cmp++;
        if (cyc != 3) begin
            n_err++;
            $display("FAIL factor_cycles: got %0d expected 3", cyc);
        end
    endtask

    task automatic test_stall();
        int cyc;
        logic [CW-1:0] c0;
        send({32'hBEEF0003, 32'hBEEF0002, 32'hBEEF0001, 32'hBEEF0000}, 4'b1111, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        acc_ready_i = 1'b0;
        c0 = add_cnt_o;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            n_cmp++;
            if (add_valid_o !== 1'b1 || add_o !== 32'hBEEF0001 || add_cnt_o !== c0) begin
                n_err++;
                $display("FAIL stall_hold: got valid %b add %h cnt %0d expected 1 beef0001 %0d",
                         add_valid_o, add_o, add_cnt_o, c0);
            end
        end
        acc_ready_i = 1'b1;
        wait_idle(50, 1'b0, cyc);
    endtask

    task automatic test_empty();
        send('0, 4'b0000, 1'b0, 16'h0, 1'b1, 1'b0);
        n_cmp++;
        if ({done_o, add_valid_o, mul_valid_o} !== 3'b100) begin
            n_err++;
            $display("FAIL empty_done: got %b expected 100", {done_o, add_valid_o, mul_valid_o});
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if ({in_ready_o, done_o} !== 2'b10) begin
            n_err++;
            $display("FAIL empty_pulse: got %b expected 10", {in_ready_o, done_o});
        end
        send('0, 4'b0000, 1'b0, 16'h0, 1'b0, 1'b0);
        n_cmp++;
        if ({in_ready_o, done_o, add_valid_o, mul_valid_o} !== 4'b1000) begin
            n_err++;
            $display("FAIL empty_nolast: got %b expected 1000", {in_ready_o, done_o, add_valid_o, mul_valid_o});
        end
    endtask

    task automatic test_abort(input bit use_rst);
        send({32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000}, 4'b1111, 1'b0, 16'h0, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (add_o !== 32'hC0000002) begin
            n_err++;
            $display("FAIL abort_pre: got %h expected c0000002", add_o);
        end
        acc_ready_i = 1'b0;
        if (use_rst) rst_ni = 1'b0; else clear_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if ({in_ready_o, add_valid_o, mul_valid_o, done_o, add_cnt_o} !== {4'b1000, 4'd0}) begin
            n_err++;
            $display("FAIL abort_%s: got %b cnt %0d expected 1000 cnt 0", use_rst ? "rst" : "clear",
                     {in_ready_o, add_valid_o, mul_valid_o, done_o}, add_cnt_o);
        end
        q.delete();
        rst_ni = 1'b1;
        clear_i = 1'b0;
        acc_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: got %b expected 0", done_o);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        for (int b = 0; b < 5; b++) begin
            send({$urandom, $urandom, $urandom, $urandom}, b < 4 ? 4'b1111 : 4'b0001, 1'b0, 16'h0, 1'b0, 1'b0);
            wait_idle(50, 1'b0, cyc);
        end
        n_cmp++;
        if (add_cnt_o !== (CNT_ON ? 4'd1 : 4'd0)) begin
            n_err++;
            $display("FAIL wrap_cnt: got %0d expected %0d", add_cnt_o, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int b = 0; b < 12; b++)
            send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 1'($urandom), 16'($urandom),
                 1'($urandom), 1'b1);
        wait_idle(300, 1'b1, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_beat();
        test_factor();
        test_stall();
        test_empty();
        test_abort(1'b0);
        test_abort(1'b1);
        test_wrap();
        test_back_to_back();
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
